usb_cdc_tx_arb: RTL and testbench

Round-robin arbiter that shares the single TX FIFO write port of the USB CDC wrapper between NREQ byte-stream requesters (e.g. console, debug log, DMA).
- Grants are frame-atomic: the bytes of one frame from one requester are never interleaved with another's.
- A frame ends on the last flag, on MAX_BURST bytes, or on a stall timeout.
- Sits between on-chip byte producers and the wrapper's tx_fifo_wr/tx_fifo_wdata/tx_fifo_full/tx_fifo_level.

---
 rtl/usb_cdc_tx_arb.sv | 127 ++++++++++++
 tb/tb_usb_cdc_tx_arb.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/usb_cdc_tx_arb.sv
// Round-robin, frame-atomic arbiter sharing the USB CDC TX FIFO write port among NREQ
// byte-stream requesters. A grant ends on last, after MAX_BURST bytes, or on stall timeout.
module usb_cdc_tx_arb #(
  parameter int unsigned NREQ      = 2,
  parameter int unsigned MAX_BURST = 8,
  parameter int unsigned TIMEOUT   = 255,
  parameter int unsigned MIN_SPACE = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [8*NREQ-1:0] req_data,
  input  logic [NREQ-1:0]   req_last,
  output logic [NREQ-1:0]   req_ready,
  output logic              tx_fifo_wr,
  output logic [7:0]        tx_fifo_wdata,
  input  logic              tx_fifo_full,
  input  logic [3:0]        tx_fifo_level,
  output logic [NREQ-1:0]   grant_o,
  output logic              abort_o,
  output logic              busy_o
);

  localparam int unsigned PW = $clog2(NREQ);

  typedef enum logic {StIdle, StGrant} state_e;

  state_e          r_state, w_state_nxt;
  logic [PW-1:0]   r_owner, w_owner_nxt;
  logic [PW-1:0]   r_rr_ptr, w_rr_nxt;
  logic [7:0]      r_burst_cnt, w_burst_nxt;
  logic [7:0]      r_to_cnt, w_to_nxt;
  logic [PW-1:0]   w_pick;
  logic [4:0]      w_free;
  logic [7:0]      w_sel_data;
  logic            w_accept;
  logic            w_release;

  // Level wraps to 0 when full, so the full flag must override it.
  assign w_free = tx_fifo_full ? 5'd0 : 5'd16 - {1'b0, tx_fifo_level};

  // First valid requester at or after rr_ptr; smallest offset is written last and wins.
  always_comb begin
    int idx;
    w_pick = r_rr_ptr;
    idx    = 0;
    for (int i = int'(NREQ) - 1; i >= 0; i--) begin
      idx = int'(r_rr_ptr) + i;
      if (idx >= int'(NREQ)) idx = idx - int'(NREQ);
      if (req_valid[idx]) w_pick = PW'(idx);
    end
  end

  always_comb begin
    w_sel_data = 8'd0;
    for (int i = 0; i < int'(NREQ); i++) begin
      if (r_owner == PW'(i)) w_sel_data = req_data[8*i +: 8];
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_owner_nxt   = r_owner;
    w_rr_nxt      = r_rr_ptr;
    w_burst_nxt   = r_burst_cnt;
    w_to_nxt      = r_to_cnt;
    w_accept      = 1'b0;
    w_release     = 1'b0;
    req_ready     = '0;
    tx_fifo_wr    = 1'b0;
    tx_fifo_wdata = 8'd0;
    grant_o       = '0;
    abort_o       = 1'b0;
    busy_o        = 1'b0;

    unique case (r_state)
      StIdle: begin
        if ((|req_valid) && (w_free >= 5'(MIN_SPACE))) begin
          w_state_nxt = StGrant;
          w_owner_nxt = w_pick;
        end
      end
      StGrant: begin
        busy_o             = 1'b1;
        grant_o[r_owner]   = 1'b1;
        req_ready[r_owner] = ~tx_fifo_full;
        w_accept           = req_valid[r_owner] & ~tx_fifo_full;
        tx_fifo_wr         = w_accept;
        tx_fifo_wdata      = w_sel_data;
        if (w_accept) begin
          w_burst_nxt = r_burst_cnt + 8'd1;
          w_to_nxt    = 8'd0;
          if (req_last[r_owner] || (r_burst_cnt + 8'd1 == 8'(MAX_BURST))) w_release = 1'b1;
        end else if (r_to_cnt + 8'd1 == 8'(TIMEOUT)) begin
          w_release = 1'b1;
          abort_o   = 1'b1;
        end else begin
          w_to_nxt = r_to_cnt + 8'd1;
        end
        if (w_release) begin
          w_state_nxt = StIdle;
          w_rr_nxt    = (r_owner == PW'(NREQ - 1)) ? '0 : r_owner + PW'(1);
          w_burst_nxt = 8'd0;
          w_to_nxt    = 8'd0;
        end
      end
      default: w_state_nxt = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= StIdle;
      r_owner     <= '0;
      r_rr_ptr    <= '0;
      r_burst_cnt <= 8'd0;
      r_to_cnt    <= 8'd0;
    end else begin
      r_state     <= w_state_nxt;
      r_owner     <= w_owner_nxt;
      r_rr_ptr    <= w_rr_nxt;
      r_burst_cnt <= w_burst_nxt;
      r_to_cnt    <= w_to_nxt;
    end
  end

endmodule

// File: tb/tb_usb_cdc_tx_arb.sv
// Directed bench for usb_cdc_tx_arb (NREQ=2, MAX_BURST=8, TIMEOUT=4, MIN_SPACE=1).
module tb_usb_cdc_tx_arb;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [1:0]  req_valid = '0;
  logic [15:0] req_data = '0;
  logic [1:0]  req_last = '0;
  logic [1:0]  req_ready;
  logic        tx_fifo_wr;
  logic [7:0]  tx_fifo_wdata;
  logic        tx_fifo_full = 1'b0;
  logic [3:0]  tx_fifo_level = 4'd0;
  logic [1:0]  grant_o;
  logic        abort_o;
  logic        busy_o;

  int n_chk = 0;
  int n_err = 0;

  logic [7:0] c0n, c1n;
  logic       r1done;

  int eg2 [12] = '{0, 1, 1, 0, 2, 2, 0, 1, 1, 0, 2, 2};
  int ed2 [12] = '{0, 'h00, 'h01, 0, 'h10, 'h11, 0, 'h02, 'h03, 0, 'h12, 'h13};
  int eg3 [13] = '{0, 1, 1, 1, 1, 1, 1, 1, 1, 0, 2, 0, 1};
  int ed3 [13] = '{0, 0, 1, 2, 3, 4, 5, 6, 7, 0, 'hB0, 0, 8};
  int fu4 [10] = '{0, 0, 0, 1, 1, 1, 0, 0, 0, 0};
  int ew4 [10] = '{0, 1, 1, 0, 0, 0, 1, 1, 1, 0};
  int eb4 [10] = '{0, 1, 1, 1, 1, 1, 1, 1, 1, 0};
  int ed4 [10] = '{0, 'hC0, 'hC1, 0, 0, 0, 'hC2, 'hC3, 'hC4, 0};
  int eg5 [7]  = '{0, 1, 1, 1, 1, 1, 0};
  int ea5 [7]  = '{0, 0, 0, 0, 0, 1, 0};

  usb_cdc_tx_arb #(
    .NREQ      (2),
    .MAX_BURST (8),
    .TIMEOUT   (4),
    .MIN_SPACE (1)
  ) u_dut (
    .clk           (clk),
    .rst           (rst),
    .req_valid     (req_valid),
    .req_data      (req_data),
    .req_last      (req_last),
    .req_ready     (req_ready),
    .tx_fifo_wr    (tx_fifo_wr),
    .tx_fifo_wdata (tx_fifo_wdata),
    .tx_fifo_full  (tx_fifo_full),
    .tx_fifo_level (tx_fifo_level),
    .grant_o       (grant_o),
    .abort_o       (abort_o),
    .busy_o        (busy_o)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Inputs change 1 ns after the edge; outputs are sampled 2 ns later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic do_reset();
    rst           = 1'b1;
    req_valid     = '0;
    req_last      = '0;
    req_data      = '0;
    tx_fifo_full  = 1'b0;
    tx_fifo_level = 4'd0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  initial begin
    // Reset state and single 3-byte frame from requester 0
    do_reset();
    settle();
    check_eq("rst_grant", 32'(grant_o), 32'd0);
    check_eq("rst_busy", 32'(busy_o), 32'd0);
    check_eq("rst_ready", 32'(req_ready), 32'd0);
    check_eq("rst_wr", 32'(tx_fifo_wr), 32'd0);
    check_eq("rst_abort", 32'(abort_o), 32'd0);
    check_eq("rst_wdata", 32'(tx_fifo_wdata), 32'd0);
    req_valid     = 2'b01;
    req_data[7:0] = 8'hA1;
    settle();
    check_eq("t1_lat_grant", 32'(grant_o), 32'd0);
    check_eq("t1_lat_ready", 32'(req_ready), 32'd0);
    tick(); settle();
    check_eq("t1_grant", 32'(grant_o), 32'd1);
    check_eq("t1_wr0", 32'(tx_fifo_wr), 32'd1);
    check_eq("t1_d0", 32'(tx_fifo_wdata), 32'hA1);
    tick();
    req_data[7:0] = 8'hA2;
    settle();
    check_eq("t1_wr1", 32'(tx_fifo_wr), 32'd1);
    check_eq("t1_d1", 32'(tx_fifo_wdata), 32'hA2);
    tick();
    req_data[7:0] = 8'hA3;
    req_last      = 2'b01;
    settle();
    check_eq("t1_d2", 32'(tx_fifo_wdata), 32'hA3);
    check_eq("t1_busy", 32'(busy_o), 32'd1);
    tick();
    req_valid = 2'b00;
    req_last  = 2'b00;
    settle();
    check_eq("t1_busy_drop", 32'(busy_o), 32'd0);
    check_eq("t1_grant_drop", 32'(grant_o), 32'd0);
    // rr_ptr now points at requester 1
    req_valid = 2'b11;
    req_last  = 2'b11;
    tick(); settle();
    check_eq("t1_rr_next", 32'(grant_o), 32'd2);

    // Both requesters always valid, 2-byte frames
    do_reset();
    req_valid = 2'b11;
    c0n = 8'd0;
    c1n = 8'd0;
    for (int cyc = 0; cyc < 12; cyc++) begin
      if (cyc > 0) tick();
      req_data = {4'h1, c1n[3:0], 4'h0, c0n[3:0]};
      req_last = {c1n[0], c0n[0]};
      settle();
      check_eq($sformatf("t2_grant_c%0d", cyc), 32'(grant_o), eg2[cyc]);
      if (eg2[cyc] != 0) check_eq($sformatf("t2_data_c%0d", cyc), 32'(tx_fifo_wdata), ed2[cyc]);
      if (req_ready[0]) c0n = c0n + 8'd1;
      if (req_ready[1]) c1n = c1n + 8'd1;
    end

    // Requester 0 streams without last; MAX_BURST forces a handover to requester 1
    do_reset();
    c0n    = 8'd0;
    r1done = 1'b0;
    for (int cyc = 0; cyc < 13; cyc++) begin
      if (cyc > 0) tick();
      req_data  = {8'hB0, c0n};
      req_last  = 2'b10;
      req_valid = {~r1done, 1'b1};
      settle();
      check_eq($sformatf("t3_grant_c%0d", cyc), 32'(grant_o), eg3[cyc]);
      if (eg3[cyc] != 0) check_eq($sformatf("t3_data_c%0d", cyc), 32'(tx_fifo_wdata), ed3[cyc]);
      check_eq($sformatf("t3_abort_c%0d", cyc), 32'(abort_o), 32'd0);
      if (req_ready[0]) c0n = c0n + 8'd1;
      if (req_ready[1]) r1done = 1'b1;
    end

    // FIFO full for 3 cycles mid-frame
    do_reset();
    c0n = 8'd0;
    for (int cyc = 0; cyc < 10; cyc++) begin
      if (cyc > 0) tick();
      tx_fifo_full  = fu4[cyc][0];
      req_data[7:0] = 8'hC0 + c0n;
      req_last[0]   = (c0n == 8'd4);
      req_valid[0]  = (c0n < 8'd5);
      settle();
      check_eq($sformatf("t4_wr_c%0d", cyc), 32'(tx_fifo_wr), ew4[cyc]);
      check_eq($sformatf("t4_ready_c%0d", cyc), 32'(req_ready), ew4[cyc]);
      check_eq($sformatf("t4_busy_c%0d", cyc), 32'(busy_o), eb4[cyc]);
      check_eq($sformatf("t4_abort_c%0d", cyc), 32'(abort_o), 32'd0);
      if (ew4[cyc] != 0) check_eq($sformatf("t4_data_c%0d", cyc), 32'(tx_fifo_wdata), ed4[cyc]);
      if (req_ready[0] && req_valid[0]) c0n = c0n + 8'd1;
    end

    // Granted requester goes silent; TIMEOUT=4 forces an abort
    do_reset();
    c0n = 8'd0;
    for (int cyc = 0; cyc < 7; cyc++) begin
      if (cyc > 0) tick();
      req_valid[0]  = (c0n == 8'd0);
      req_data[7:0] = 8'hD0;
      req_last      = 2'b00;
      settle();
      check_eq($sformatf("t5_grant_c%0d", cyc), 32'(grant_o), eg5[cyc]);
      check_eq($sformatf("t5_abort_c%0d", cyc), 32'(abort_o), ea5[cyc]);
      if (req_ready[0] && req_valid[0]) c0n = c0n + 8'd1;
    end

    // Full with wrapped level blocks grants; exactly MIN_SPACE free allows one; reset mid-frame
    do_reset();
    tx_fifo_full  = 1'b1;
    tx_fifo_level = 4'd0;
    req_valid     = 2'b01;
    req_data      = 16'h00E0;
    req_last      = 2'b01;
    for (int cyc = 0; cyc < 3; cyc++) begin
      settle();
      check_eq($sformatf("t6_full_grant_c%0d", cyc), 32'(grant_o), 32'd0);
      check_eq($sformatf("t6_full_busy_c%0d", cyc), 32'(busy_o), 32'd0);
      tick();
    end
    tx_fifo_full  = 1'b0;
    tx_fifo_level = 4'd15;
    tick(); settle();
    check_eq("t6_minspace_grant", 32'(grant_o), 32'd1);
    check_eq("t6_minspace_wr", 32'(tx_fifo_wr), 32'd1);
    rst = 1'b1;
    tick(); settle();
    check_eq("t6_rst_grant", 32'(grant_o), 32'd0);
    check_eq("t6_rst_busy", 32'(busy_o), 32'd0);
    check_eq("t6_rst_ready", 32'(req_ready), 32'd0);
    check_eq("t6_rst_wr", 32'(tx_fifo_wr), 32'd0);
    rst = 1'b0;

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
